instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage between the instruction memory and the instruction decoder. On a start pulse it streams `num_inst` consecutive 32-bit instruction words out of the instruction memory's read-only port B, beginning at `start_addr`. It buffers them in a small prefetch FIFO and presents them to the decoder on a valid/ready interface. It hides the memory's 1-cycle read latency and absorbs decoder back-pressure without losing or duplicating words.

## Interface
- `DATA_WIDTH`, 32: instruction word width; must equal the instruction memory's DATA_WIDTH.
- `ADDR_WIDTH`, 11: word address width of the instruction memory (2048 words).
- `FIFO_DEPTH`, 4: prefetch FIFO entries; power of two, ≥2.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low reset; all state clears while low; deassertion is synchronous to `clk` upstream.
- `start` in 1: 1-cycle pulse; sampled only in IDLE.
- `start_addr` in ADDR_WIDTH: first word address, sampled with `start`.
- `num_inst` in ADDR_WIDTH+1: word count, sampled with `start`; 0 is legal.
- `abort` in 1: level; cancels the current fetch.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: 1-cycle pulse after the last word is accepted by the decoder.
- `imem_read_req` out 1: drives imem `s_read_req_b`.
- `imem_read_addr` out ADDR_WIDTH: drives imem `s_read_addr_b`.
- `imem_read_data` in DATA_WIDTH: from imem `s_read_data_b`; valid the cycle after `imem_read_req`.
- `inst_valid` out 1: FIFO head valid.
- `inst_data` out DATA_WIDTH: FIFO head word.
- `inst_ready` in 1: decoder accepts the word when `inst_valid && inst_ready`.

## Operation
- **States:** IDLE, FETCH, DRAIN, DONE.
- **IDLE → FETCH** on `start` with `num_inst != 0`. Load `addr_q = start_addr` and `remain_q = num_inst`.
- **IDLE → DONE** on `start` with `num_inst == 0`.
- **Issue rule (FETCH only):** assert `imem_read_req` when `remain_q != 0 && (fifo_count + pend_q) < FIFO_DEPTH`. `pend_q` is a 1-bit in-flight flag.
  - On issue: `addr_q` increments, wrapping modulo 2^ADDR_WIDTH with no error; `remain_q` decrements.
  - `pend_q` is set on the issue cycle. It is cleared the following cycle unless that cycle issues again.
- **Return:** while `pend_q` is set, `imem_read_data` is pushed into the FIFO. The credit check guarantees the FIFO is never full on a push.
- **FETCH → DRAIN** on the cycle that issues the last request (`remain_q == 1` and issuing).
- **DRAIN → DONE** when `pend_q == 0`, the FIFO is empty, and no push is occurring.
- **DONE → IDLE** unconditionally after one cycle; `done` is asserted in DONE.
- **Simultaneous push and pop:** allowed in the same cycle; `fifo_count` is unchanged.
- **`start` while busy:** ignored, with no effect on sampled values.
- **`abort` in any non-IDLE state:**
  - Next state is IDLE; FIFO pointers and count clear; `pend_q` clears.
  - Any return arriving in the following cycle is discarded.
  - `done` is not pulsed. `inst_valid` is low from the cycle after `abort`.
  - `abort` in IDLE has no effect.
- **Reset mid-operation:** immediate return to IDLE with all outputs at reset values. No done and no further requests.
- **Output reset values:** `busy`, `done`, `imem_read_req`, and `inst_valid` are 0. `imem_read_addr` and `inst_data` are 0 (FIFO storage is reset).
- **`imem_read_addr`** equals `addr_q` at all times.

## Timing
- `start` in cycle 0 → first `imem_read_req` in cycle 1 → data pushed at the end of cycle 2 → `inst_valid` in cycle 3. Start-to-first-instruction latency is 3 cycles.
- **Throughput:** with `inst_ready` held high and `FIFO_DEPTH` ≥ 2, one instruction per cycle is sustained.
- **Sequence length:** N words with `inst_ready` always high gives `inst_valid` in cycles 3..N+2 and `done` in cycle N+3.
- `inst_valid` and `inst_data` come from registered FIFO state, with no combinational path from `inst_ready`.
- `imem_read_req` depends combinationally on `inst_ready` only through the same-cycle pop freeing a credit. This path is permitted.

## Structure
- **Shared package** `instruction_fetch_pkg`:
  - state width and encodings (IDLE=0, FETCH=1, DRAIN=2, DONE=3);
  - default `FIFO_DEPTH`;
  - imem word-address width derivation (`$clog2(65536/DATA_WIDTH)`), reused by the memory and the decoder.
- **One sub-module** `fetch_fifo`: a synchronous FIFO with count output, asynchronous active-low reset, and a synchronous `flush` input used by `abort`.
- The top level holds the FSM, address/remain counters, and the credit and pending logic.

## Test plan
- **Basic stream:** preload imem words 0..7 with 0xA000_0000+i; `start_addr`=0, `num_inst`=8, `inst_ready`=1 → `inst_data` = 0xA000_0000..0xA000_0007 in cycles 3..10, `done` in cycle 11, exactly 8 requests.
- **Back-pressure:** `num_inst`=16, `inst_ready` toggles 1/0 each cycle → all 16 words delivered in order, with no duplicates or drops. `fifo_count` never exceeds 4, and `imem_read_req` is never asserted with `fifo_count+pend_q`=4.
- **Address wrap:** `start_addr`=2046, `num_inst`=4 → addresses 2046, 2047, 0, 1 issued; words delivered in that order.
- **Zero count:** `start` with `num_inst`=0 → no `imem_read_req`, `busy` high 1 cycle, `done` pulse in cycle 1.
- **Abort:** `num_inst`=32, `abort` raised after the 5th accepted word while `inst_ready`=1 → `inst_valid` low next cycle, no `done`, IDLE. A new `start` afterwards fetches from the new `start_addr` with no stale words.
- **Reset mid-stream:** `reset` low during FETCH → all outputs 0 immediately (asynchronously). After release, `start` with `num_inst`=2 behaves exactly like the first run.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encodings, FIFO sizing and the
// imem word-address width helper used by the memory, fetch and decode blocks.
package instruction_fetch_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_FETCH = 2'd1;
    localparam logic [STATE_W-1:0] ST_DRAIN = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

    localparam int FIFO_DEPTH_DEF = 4;

    function automatic int imem_addr_width(input int data_width);
        return $clog2(65536 / data_width);
    endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Prefetch FIFO: registered head/valid, occupancy count, synchronous flush.
module fetch_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_WIDTH-1:0]    push_data,
    input  logic                     pop,
    output logic                     valid,
    output logic [DATA_WIDTH-1:0]    head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_push_s;
    logic                  do_pop_s;

    // Next-state for storage, pointers and occupancy; flush overrides push/pop.
    always_comb begin
        do_pop_s  = pop && (count_q != CNT_ZERO);
        do_push_s = push && ((count_q != CNT_FULL) || do_pop_s);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers, storage included so the head reads 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign valid = (count_q != CNT_ZERO);
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: streams num_inst words from imem port B into a prefetch FIFO
// and hands them to the decoder over valid/ready, hiding the 1-cycle read latency.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = imem_addr_width(DATA_WIDTH),
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   num_inst,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  imem_read_req,
    output logic [ADDR_WIDTH-1:0] imem_read_addr,
    input  logic [DATA_WIDTH-1:0] imem_read_data,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst_data,
    input  logic                  inst_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0]      DEPTH_C     = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]    CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);
    localparam logic [ADDR_WIDTH:0] REMAIN_ZERO = {(ADDR_WIDTH + 1){1'b0}};
    localparam logic [ADDR_WIDTH:0] REMAIN_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    logic [STATE_W-1:0]    state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   remain_q, remain_d;
    logic                  pend_q, pend_d;
    logic [CNT_W-1:0]      fifo_count_s;
    logic [CNT_W:0]        credit_s;
    logic                  issue_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  flush_s;
    logic                  drain_empty_s;

    // Credit check: words already buffered plus the one in flight must leave room.
    always_comb begin
        flush_s       = abort && (state_q != ST_IDLE);
        credit_s      = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, pend_q};
        issue_s       = (state_q == ST_FETCH) && !abort &&
                        (remain_q != REMAIN_ZERO) && (credit_s < DEPTH_C);
        pop_s         = inst_valid && inst_ready;
        push_s        = pend_q && !flush_s;
        // Empty counts the same-cycle pop so done lands right after the last accept.
        drain_empty_s = !pend_q && ((fifo_count_s == CNT_ZERO) ||
                                    ((fifo_count_s == CNT_ONE) && pop_s));
    end

    // FSM and address/remain/pending next-state.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        pend_d   = issue_s;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_inst != REMAIN_ZERO) begin
                        state_d  = ST_FETCH;
                        addr_d   = start_addr;
                        remain_d = num_inst;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (issue_s && (remain_q == REMAIN_ONE)) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (drain_empty_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (issue_s) begin
            addr_d   = addr_q + ADDR_ONE;
            remain_d = remain_q - REMAIN_ONE;
        end else begin
            pend_d = 1'b0;
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= {ADDR_WIDTH{1'b0}};
            remain_q <= REMAIN_ZERO;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            pend_q   <= pend_d;
        end
    end

    fetch_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .flush      (flush_s),
        .push       (push_s),
        .push_data  (imem_read_data),
        .pop        (pop_s),
        .valid      (inst_valid),
        .head       (inst_data),
        .count      (fifo_count_s)
    );

    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);
    assign imem_read_req  = issue_s;
    assign imem_read_addr = addr_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural 1-cycle-latency imem.
module tb_instruction_fetch;

    localparam int ADDR_W     = 11;
    localparam int DATA_W     = 32;
    localparam int IMEM_WORDS = 2048;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   num_inst;
    logic              abort;
    logic              busy;
    logic              done;
    logic              imem_read_req;
    logic [ADDR_W-1:0] imem_read_addr;
    logic [DATA_W-1:0] imem_read_data;
    logic              inst_valid;
    logic [DATA_W-1:0] inst_data;
    logic              inst_ready;

    logic [DATA_W-1:0] mem [IMEM_WORDS];

    int n_checks = 0;
    int n_errors = 0;

    int r_first, r_done, r_req, r_acc, r_addr_bad, r_cred_bad, r_max_out;
    int r_late, r_busy_cycles;
    logic r_valid_after, r_busy_after;

    instruction_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .start_addr     (start_addr),
        .num_inst       (num_inst),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .imem_read_req  (imem_read_req),
        .imem_read_addr (imem_read_addr),
        .imem_read_data (imem_read_data),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_ready     (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_read_req) imem_read_data <= mem[imem_read_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always high; mode 1: ready high on odd cycles only.
    task automatic run_stream(input logic [ADDR_W-1:0] sa, input logic [ADDR_W:0] n,
                              input int mode, input int abort_cyc, input int budget);
        int issued;
        int outst;
        issued = 0;
        r_first = -1; r_done = -1; r_acc = 0; r_addr_bad = 0; r_cred_bad = 0;
        r_max_out = 0; r_late = 0; r_busy_cycles = 0;
        r_valid_after = 1'b1; r_busy_after = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; start_addr = sa; num_inst = n; inst_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start_addr = 11'd0; num_inst = 12'd0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            inst_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 1);
            abort = (cyc == abort_cyc);
            #1;
            outst = issued - r_acc;
            if (outst > r_max_out) r_max_out = outst;
            if (imem_read_req) begin
                if (imem_read_addr !== ADDR_W'((int'(sa) + issued) % IMEM_WORDS)) r_addr_bad++;
                if (outst >= 4) r_cred_bad++;
                if (abort_cyc > 0 && cyc > abort_cyc) r_late++;
                issued++;
            end
            if (abort_cyc > 0 && cyc == abort_cyc + 1) begin
                r_valid_after = inst_valid;
                r_busy_after  = busy;
            end
            if (inst_valid && r_first < 0) r_first = cyc;
            if (inst_valid && inst_ready) begin
                check_eq("word", inst_data, mem[(int'(sa) + r_acc) % IMEM_WORDS]);
                r_acc++;
                if (abort_cyc > 0 && cyc > abort_cyc) r_late++;
            end
            if (busy) r_busy_cycles++;
            if (done) r_done = cyc;
            if (r_done >= 0) break;
            if (abort_cyc > 0 && cyc == abort_cyc + 5) break;
            @(posedge clk); #1;
        end
        abort = 1'b0;
        r_req = issued;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < IMEM_WORDS; i++) mem[i] = 32'hA000_0000 + 32'(i);
        reset = 1'b0; start = 1'b0; start_addr = 11'd0; num_inst = 12'd0;
        abort = 1'b0; inst_ready = 1'b0; imem_read_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_req", 32'(imem_read_req), 32'd0);
        check_eq("rst_addr", 32'(imem_read_addr), 32'd0);
        check_eq("rst_valid", 32'(inst_valid), 32'd0);
        check_eq("rst_data", inst_data, 32'd0);
        reset = 1'b1;

        // Basic stream of 8 words
        run_stream(11'd0, 12'd8, 0, 0, 30);
        check_eq("basic_first", 32'(r_first), 32'd3);
        check_eq("basic_done", 32'(r_done), 32'd11);
        check_eq("basic_req", 32'(r_req), 32'd8);
        check_eq("basic_acc", 32'(r_acc), 32'd8);
        check_eq("basic_addr", 32'(r_addr_bad), 32'd0);
        check_eq("basic_busy", 32'(r_busy_cycles), 32'd11);
        @(posedge clk); #1;
        check_eq("basic_idle", 32'(busy), 32'd0);
        check_eq("basic_done_pulse", 32'(done), 32'd0);

        // Back-pressure: ready toggles
        run_stream(11'd40, 12'd16, 1, 0, 120);
        check_eq("bp_acc", 32'(r_acc), 32'd16);
        check_eq("bp_req", 32'(r_req), 32'd16);
        check_eq("bp_credit", 32'(r_cred_bad), 32'd0);
        check_eq("bp_max_out_le4", 32'(r_max_out <= 4), 32'd1);
        check_eq("bp_addr", 32'(r_addr_bad), 32'd0);
        check_eq("bp_done_seen", 32'(r_done > 0), 32'd1);

        // Address wrap 2046,2047,0,1
        run_stream(11'd2046, 12'd4, 0, 0, 30);
        check_eq("wrap_acc", 32'(r_acc), 32'd4);
        check_eq("wrap_addr", 32'(r_addr_bad), 32'd0);
        check_eq("wrap_done", 32'(r_done), 32'd7);

        // Zero count
        run_stream(11'd5, 12'd0, 0, 0, 10);
        check_eq("zero_done", 32'(r_done), 32'd1);
        check_eq("zero_req", 32'(r_req), 32'd0);
        check_eq("zero_busy", 32'(r_busy_cycles), 32'd1);
        check_eq("zero_valid", 32'(r_first), 32'hFFFF_FFFF);

        // Abort in cycle 8, right after the 5th word was accepted in cycle 7
        run_stream(11'd300, 12'd32, 0, 8, 40);
        check_eq("abort_acc", 32'(r_acc), 32'd6);
        check_eq("abort_valid_after", 32'(r_valid_after), 32'd0);
        check_eq("abort_busy_after", 32'(r_busy_after), 32'd0);
        check_eq("abort_late", 32'(r_late), 32'd0);
        check_eq("abort_no_done", 32'(r_done), 32'hFFFF_FFFF);

        run_stream(11'd100, 12'd3, 0, 0, 30);
        check_eq("post_abort_first", 32'(r_first), 32'd3);
        check_eq("post_abort_done", 32'(r_done), 32'd6);
        check_eq("post_abort_acc", 32'(r_acc), 32'd3);

        // Reset mid-stream
        @(posedge clk); #1;
        start = 1'b1; start_addr = 11'd0; num_inst = 12'd8; inst_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("mid_pre_valid", 32'(inst_valid), 32'd1);
        check_eq("mid_pre_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check_eq("mid_busy", 32'(busy), 32'd0);
        check_eq("mid_req", 32'(imem_read_req), 32'd0);
        check_eq("mid_addr", 32'(imem_read_addr), 32'd0);
        check_eq("mid_valid", 32'(inst_valid), 32'd0);
        check_eq("mid_data", inst_data, 32'd0);
        check_eq("mid_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_after_busy", 32'(busy), 32'd0);
        check_eq("mid_after_req", 32'(imem_read_req), 32'd0);
        run_stream(11'd0, 12'd2, 0, 0, 20);
        check_eq("rerun_first", 32'(r_first), 32'd3);
        check_eq("rerun_done", 32'(r_done), 32'd5);
        check_eq("rerun_req", 32'(r_req), 32'd2);
        check_eq("rerun_acc", 32'(r_acc), 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
